// File: rtl/spi_3wire_master_pkg.sv
// Shared types and constants for the 3-wire SPI register protocol master.
package spi_3wire_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4,
        GAP      = 3'd5
    } state_e;

    localparam int   FRAME_BITS      = 16;
    localparam int   ADDR_BITS       = 7;
    localparam int   DATA_BITS       = 8;
    localparam logic RW_READ         = 1'b1;
    localparam logic RW_WRITE        = 1'b0;
    localparam int   DATA_OE_DROP_RD = 8;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic                 rw,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] data
    );
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_3wire_master_if.sv
// Request/response and bus-side signals of the 3-wire SPI master.
// req_full exists only when SPI_MASTER_REQ_QUEUE_EN is defined.
interface spi_3wire_master_if;
    import spi_3wire_pkg::*;

    logic                 start;
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 busy;
    logic                 done;
    logic [DATA_BITS-1:0] rdata;
    logic                 sclk;
    logic                 ss_n;
    logic                 sdata_out;
    logic                 sdata_oe;
    logic                 sdata_in;
`ifdef SPI_MASTER_REQ_QUEUE_EN
    logic                 req_full;
`endif

    modport master (
`ifdef SPI_MASTER_REQ_QUEUE_EN
        output req_full,
`endif
        input  start, rw, addr, wdata, sdata_in,
        output busy, done, rdata, sclk, ss_n, sdata_out, sdata_oe
    );

    modport slave (
`ifdef SPI_MASTER_REQ_QUEUE_EN
        input  req_full,
`endif
        output start, rw, addr, wdata, sdata_in,
        input  busy, done, rdata, sclk, ss_n, sdata_out, sdata_oe
    );

endinterface

// File: rtl/spi_3wire_master_timer.sv
// Free-running half-period timer: one-cycle tick every CLK_DIV cycles, held at zero by clr_i.
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n_sync,
    input  logic clr_i,
    output logic tick_o
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: wrap on the last cycle of a half-period or when cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/spi_3wire_master.sv
// 3-wire SPI master: serialises {rw, addr, data} frames, MSB first, at clk/(2*CLK_DIV).
// Optional one-entry request buffer: define SPI_MASTER_REQ_QUEUE_EN.
module spi_3wire_master
    import spi_3wire_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_HALVES = 2
) (
    input  logic                clk,
    input  logic                rst_n_sync,
    spi_3wire_master_if.master  bus
);
    localparam logic [7:0] GAP_LAST = 8'(GAP_HALVES - 1);

    state_e                  state_q;
    logic [FRAME_BITS-1:0]   sr_q;
    logic                    rw_q;
    logic [3:0]              bit_q;
    logic [7:0]              gap_q;
    logic                    sclk_q;
    logic                    ss_n_q;
    logic                    oe_q;
    logic                    sout_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_BITS-1:0]    rdata_q;
    logic                    tick_s;
    logic                    gap_end_s;
    logic                    launch_s;
    logic [FRAME_BITS-1:0]   launch_frame_s;
`ifdef SPI_MASTER_REQ_QUEUE_EN
    logic [FRAME_BITS-1:0]   qreq_q;
    logic                    req_full_q;
`endif

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .clr_i      (state_q == IDLE),
        .tick_o     (tick_s)
    );

    assign gap_end_s = (state_q == GAP) && tick_s && (gap_q == GAP_LAST);

    // Frame launch: a fresh start in IDLE, or the buffered request (which may chain straight out of GAP).
    always_comb begin
        launch_frame_s = pack_frame(bus.rw, bus.addr, bus.wdata);
`ifdef SPI_MASTER_REQ_QUEUE_EN
        if (req_full_q) begin
            launch_frame_s = qreq_q;
        end else begin
            launch_frame_s = pack_frame(bus.rw, bus.addr, bus.wdata);
        end
        if (state_q == IDLE) begin
            launch_s = req_full_q || bus.start;
        end else begin
            launch_s = gap_end_s && req_full_q;
        end
`else
        if (state_q == IDLE) begin
            launch_s = bus.start;
        end else begin
            launch_s = 1'b0;
        end
`endif
    end

    // Frame FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= IDLE;
            sr_q    <= 16'h0000;
            rw_q    <= 1'b0;
            bit_q   <= 4'd0;
            gap_q   <= 8'd0;
            sclk_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
`ifdef SPI_MASTER_REQ_QUEUE_EN
            qreq_q     <= 16'h0000;
            req_full_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef SPI_MASTER_REQ_QUEUE_EN
            if (bus.start && (state_q != IDLE) && !req_full_q) begin
                qreq_q     <= pack_frame(bus.rw, bus.addr, bus.wdata);
                req_full_q <= 1'b1;
            end else if (launch_s && req_full_q) begin
                req_full_q <= 1'b0;
            end
`endif
            if (launch_s) begin
                sr_q    <= launch_frame_s;
                rw_q    <= launch_frame_s[FRAME_BITS-1];
                sout_q  <= launch_frame_s[FRAME_BITS-1];
                oe_q    <= 1'b1;
                ss_n_q  <= 1'b0;
                busy_q  <= 1'b1;
                bit_q   <= 4'd0;
                gap_q   <= 8'd0;
                state_q <= SETUP;
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    SETUP: begin
                        if (tick_s) begin
                            sclk_q  <= 1'b1;
                            state_q <= SHIFT_HI;
                        end
                    end
                    SHIFT_HI: begin
                        if (tick_s) begin
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                oe_q    <= 1'b0;
                                state_q <= HOLD;
                            end else begin
                                sr_q   <= {sr_q[FRAME_BITS-2:0], 1'b0};
                                sout_q <= sr_q[FRAME_BITS-2];
                                if ((rw_q == RW_READ) && (bit_q == 4'(DATA_OE_DROP_RD - 1))) begin
                                    oe_q <= 1'b0;
                                end
                                bit_q   <= bit_q + 4'd1;
                                state_q <= SHIFT_LO;
                            end
                        end
                    end
                    SHIFT_LO: begin
                        if (tick_s) begin
                            sclk_q <= 1'b1;
                            // Captured bits enter at bit 0 and ride the left shift up to [7:0].
                            if ((rw_q == RW_READ) && (bit_q >= 4'(DATA_OE_DROP_RD))) begin
                                sr_q[0] <= bus.sdata_in;
                            end
                            state_q <= SHIFT_HI;
                        end
                    end
                    HOLD: begin
                        if (tick_s) begin
                            ss_n_q <= 1'b1;
                            done_q <= 1'b1;
                            if (rw_q == RW_READ) begin
                                rdata_q <= sr_q[DATA_BITS-1:0];
                            end
                            state_q <= GAP;
                        end
                    end
                    GAP: begin
                        if (tick_s) begin
                            if (gap_q == GAP_LAST) begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                gap_q <= gap_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.ss_n      = ss_n_q;
    assign bus.sdata_out = sout_q;
    assign bus.sdata_oe  = oe_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
`ifdef SPI_MASTER_REQ_QUEUE_EN
    assign bus.req_full  = req_full_q;
`endif

endmodule

// File: tb/tb_spi_3wire_master.sv
// Bench for spi_3wire_master: expected waveforms derived from the frame timing arithmetic.
module tb_spi_3wire_master;
    import spi_3wire_pkg::*;

    localparam int D        = 4;
    localparam int G        = 2;
    localparam int DONE_OFS = 1 + 33 * D;
    localparam int END_OFS  = DONE_OFS + G * D;
    localparam int RISE6    = 1 + D + 5 * 2 * D;

    logic clk = 1'b0;
    logic rst_n_sync = 1'b0;
    logic slave_drv = 1'b0;
    logic [7:0] exp_rdata = 8'h00;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_3wire_master_if bus();
    assign bus.sdata_in = bus.sdata_oe ? bus.sdata_out : slave_drv;

    spi_3wire_master #(.CLK_DIV(D), .GAP_HALVES(G)) dut (
        .clk        (clk),
        .rst_n_sync (rst_n_sync),
        .bus        (bus.master)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame, cycle by cycle from T0+1; optional injected starts and mid-frame reset.
    task automatic run_frame(input bit issue, input logic rw, input logic [6:0] addr,
                             input logic [7:0] data, input logic [7:0] rbyte,
                             input int inj_at, input int rst_at,
                             output bit chained, output logic [6:0] q_addr,
                             output logic [7:0] q_data);
        int rises = 0, falls = 0, dones = 0;
        int wave_err = 0, oe_err = 0, ssn_err = 0, busy_err = 0, done_err = 0;
        logic prev_sclk = 1'b0;
        logic [15:0] seen = 16'h0000;
        logic [15:0] exp_frame = {rw, addr, (rw == RW_READ) ? rbyte : data};
        bit pend = 1'b0;
        chained = 1'b0;
        q_addr = 7'($urandom);
        q_data = 8'($urandom);
        slave_drv = 1'b0;
        if (issue) begin
            @(negedge clk);
            bus.start = 1'b1; bus.rw = rw; bus.addr = addr; bus.wdata = data;
            @(posedge clk); #1;
            bus.start = 1'b0; bus.rw = 1'($urandom); bus.addr = 7'($urandom); bus.wdata = 8'($urandom);
        end
        for (int n = 1; n < END_OFS; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            if (bus.sclk !== ((n >= 1 + D) && (n < DONE_OFS) && ((((n - 1 - D) / D) % 2) == 0))) wave_err++;
            if (bus.sdata_oe !== (n < ((rw == RW_READ) ? 1 + 16 * D : 1 + 32 * D))) oe_err++;
            if (bus.ss_n !== (n >= DONE_OFS)) ssn_err++;
            if (bus.busy !== 1'b1) busy_err++;
            if (bus.done !== (n == DONE_OFS)) done_err++;
            if (!prev_sclk && bus.sclk && rises < 16) begin
                rises++;
                seen[16 - rises] = bus.sdata_in;
            end
            if (prev_sclk && !bus.sclk) begin
                falls++;
                if (rw == RW_READ && falls >= 8 && falls < 16) slave_drv = rbyte[15 - falls];
            end
            if (bus.done === 1'b1) begin
                dones++;
                if (rw == RW_READ) exp_rdata = rbyte;
                check_eq("rdata_at_done", bus.rdata, exp_rdata);
            end
            if (inj_at > 0 && n == inj_at) begin
                bus.start = 1'b1; bus.rw = RW_WRITE; bus.addr = q_addr; bus.wdata = q_data;
            end else if (inj_at > 0 && n == inj_at + 5) begin
                bus.start = 1'b1; bus.rw = RW_WRITE; bus.addr = ~q_addr; bus.wdata = ~q_data;
            end else begin
                bus.start = 1'b0;
            end
`ifdef SPI_MASTER_REQ_QUEUE_EN
            if (inj_at > 0 && n == inj_at + 1) begin
                check_eq("req_full_set", bus.req_full, 1'b1);
                pend = 1'b1;
            end
`endif
            if (rst_at > 0 && n == rst_at) begin
                check_eq("rises_before_rst", rises, 6);
                rst_n_sync = 1'b0;
                #1;
                check_eq("rst_ss_n", bus.ss_n, 1'b1);
                check_eq("rst_sclk", bus.sclk, 1'b0);
                check_eq("rst_oe", bus.sdata_oe, 1'b0);
                check_eq("rst_busy", bus.busy, 1'b0);
                exp_rdata = 8'h00;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check_eq("rst_no_done", bus.done, 1'b0);
                end
                @(negedge clk);
                rst_n_sync = 1'b1;
                @(posedge clk); #1;
                check_eq("rst_rdata", bus.rdata, exp_rdata);
                check_eq("rst_wave", wave_err, 0);
                return;
            end
            prev_sclk = bus.sclk;
        end
        @(posedge clk); #1;
        if (pend) begin
            check_eq("chain_busy", bus.busy, 1'b1);
            check_eq("chain_ss_n", bus.ss_n, 1'b0);
            chained = 1'b1;
        end else begin
            check_eq("end_busy", bus.busy, 1'b0);
            check_eq("end_ss_n", bus.ss_n, 1'b1);
        end
        check_eq("sclk_wave", wave_err, 0);
        check_eq("oe_wave", oe_err, 0);
        check_eq("ss_n_wave", ssn_err, 0);
        check_eq("busy_wave", busy_err, 0);
        check_eq("done_wave", done_err, 0);
        check_eq("done_count", dones, 1);
        check_eq("rise_count", rises, 16);
        check_eq("bus_bits", seen, exp_frame);
        check_eq("rdata_hold", bus.rdata, exp_rdata);
    endtask

    initial begin
        bit ch;
        logic [6:0] qa, a;
        logic [7:0] qd, dd, rb;
        logic r;
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = 7'h00; bus.wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ss_n", bus.ss_n, 1'b1);
        check_eq("reset_sclk", bus.sclk, 1'b0);
        check_eq("reset_oe", bus.sdata_oe, 1'b0);
        check_eq("reset_sout", bus.sdata_out, 1'b0);
        check_eq("reset_busy", bus.busy, 1'b0);
        check_eq("reset_done", bus.done, 1'b0);
        check_eq("reset_rdata", bus.rdata, 8'h00);
        @(negedge clk);
        rst_n_sync = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(1'b1, RW_WRITE, 7'h15, 8'hA5, 8'h00, 0, 0, ch, qa, qd);
        run_frame(1'b1, RW_READ, 7'h15, 8'h00, 8'h3C, 0, 0, ch, qa, qd);
        run_frame(1'b1, RW_WRITE, 7'h2A, 8'h96, 8'h00, 50, 0, ch, qa, qd);
        if (ch) run_frame(1'b0, RW_WRITE, qa, qd, 8'h00, 0, 0, ch, qa, qd);
        run_frame(1'b1, RW_READ, 7'h33, 8'h00, 8'hC3, 0, RISE6, ch, qa, qd);
        run_frame(1'b1, RW_WRITE, 7'h7F, 8'h5A, 8'h00, 0, 0, ch, qa, qd);
        for (int i = 0; i < 10; i++) begin
            r  = 1'($urandom);
            a  = 7'($urandom);
            dd = 8'($urandom);
            rb = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_frame(1'b1, r, a, dd, rb, 0, 0, ch, qa, qd);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
